// File: rtl/panda_fetch.sv
`timescale 1ns/1ps
// Panda instruction fetch: sequential word requests, a DEPTH-entry prefetch FIFO of {pc, instr},
// and redirects that flush the FIFO and drop responses still in flight.
module panda_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);
  localparam int              PW      = (DEPTH > 2) ? 2 : 1;
  localparam int              SLOTS   = 1 << PW;
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [31:0]     BOOT_W  = BOOT_ADDR & 32'hFFFF_FFFC;

  logic          run_q, run_d;
  logic          pend_q, pend_d;
  logic          stale_q, stale_d;
  logic [31:0]   stale_addr_q, stale_addr_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [31:0]   pc_mem_q    [SLOTS];
  logic [31:0]   instr_mem_q [SLOTS];

  logic        gnt_fire, push, pop;
  logic [CW:0] occ;
  logic [31:0] resp_pc;

  // Request line is a function of registered state only; a held request keeps it up.
  assign occ          = {1'b0, count_q} + {1'b0, out_q};
  assign instr_req_o  = pend_q | (run_q & (occ < DEPTH_C));
  // A request pending across a redirect keeps its old address until granted.
  assign instr_addr_o = stale_q ? stale_addr_q : fetch_addr_q;

  assign gnt_fire = instr_req_o & instr_gnt_i;
  assign push     = instr_rvalid_i & ~redirect_i & (disc_q == '0);
  assign pop      = instr_valid_o & instr_ready_i;
  // With no discards pending, every outstanding request belongs to the current stream,
  // so the oldest one sits exactly out_q words behind fetch_addr.
  assign resp_pc  = fetch_addr_q - ({{(32-CW){1'b0}}, out_q} << 2);

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? instr_mem_q[rd_q] : 32'h0;
  assign pc_o          = instr_valid_o ? pc_mem_q[rd_q]    : 32'h0;

  always_comb begin
    run_d        = 1'b1;
    pend_d       = instr_req_o & ~instr_gnt_i;
    stale_d      = stale_q;
    stale_addr_d = stale_addr_q;
    fetch_addr_d = fetch_addr_q;
    count_d      = count_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    disc_d       = disc_q;
    out_d        = out_q + CW'(gnt_fire) - CW'(instr_rvalid_i);
    if (redirect_i) begin
      count_d      = '0;
      rd_d         = '0;
      wr_d         = '0;
      disc_d       = out_d;
      fetch_addr_d = redirect_addr_i & 32'hFFFF_FFFC;
      stale_d      = pend_d;
      stale_addr_d = instr_addr_o;
    end else begin
      if (gnt_fire) begin
        if (stale_q) stale_d = 1'b0;
        else         fetch_addr_d = fetch_addr_q + 32'd4;
      end
      disc_d = disc_q + CW'(gnt_fire & stale_q) - CW'(instr_rvalid_i && (disc_q != '0));
      if (push) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
      if (pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q        <= 1'b0;
      pend_q       <= 1'b0;
      stale_q      <= 1'b0;
      stale_addr_q <= 32'h0;
      fetch_addr_q <= BOOT_W;
      count_q      <= '0;
      out_q        <= '0;
      disc_q       <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
    end else begin
      run_q        <= run_d;
      pend_q       <= pend_d;
      stale_q      <= stale_d;
      stale_addr_q <= stale_addr_d;
      fetch_addr_q <= fetch_addr_d;
      count_q      <= count_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  // Storage needs no reset: the outputs are gated by count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_q]    <= resp_pc;
      instr_mem_q[wr_q] <= instr_rdata_i;
    end
  end

endmodule

// File: tb/tb_panda_fetch.sv
`timescale 1ns/1ps
// Directed bench for panda_fetch: main instance (DEPTH=3, boot 0) with a scriptable memory,
// plus a DEPTH=2 instance booting at 0xFFFF_FFF8 for the address wrap.
module tb_panda_fetch;
  localparam logic [31:0] K = 32'h5A5A_0000;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_ni = 1'b1;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_addr_o, instr_rdata_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = 32'h0;
  logic        instr_valid_o, instr_ready_i;
  logic [31:0] instr_o, pc_o;

  logic        w_req, w_gnt, w_rv, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;
  logic        w_redir = 1'b0;
  logic [31:0] w_raddr = 32'h0;
  logic        w_ready = 1'b1;

  panda_fetch #(.BOOT_ADDR(32'h0000_0000), .DEPTH(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o)
  );

  panda_fetch #(.BOOT_ADDR(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_o(w_req), .instr_addr_o(w_addr), .instr_gnt_i(w_gnt),
    .instr_rvalid_i(w_rv), .instr_rdata_i(w_rdata),
    .redirect_i(w_redir), .redirect_addr_i(w_raddr),
    .instr_valid_o(w_valid), .instr_ready_i(w_ready),
    .instr_o(w_instr), .pc_o(w_pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Main memory: grants when gnt_en, answers in order no earlier than the next cycle, data = addr ^ K.
  logic        gnt_en  = 1'b1;
  logic        resp_en = 1'b1;
  int          gnt_cnt = 0;
  logic [31:0] q[$];
  initial begin
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        q.delete();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
      end else begin
        instr_rvalid_i = resp_en && (q.size() > 0);
        instr_rdata_i  = instr_rvalid_i ? (q.pop_front() ^ K) : 32'h0;
        instr_gnt_i    = gnt_en && instr_req_o;
        if (instr_gnt_i) begin
          q.push_back(instr_addr_o);
          gnt_cnt++;
        end
      end
    end
  end

  // Wrap memory: always grants, answers next cycle with data = addr.
  logic        w_has = 1'b0;
  logic [31:0] w_last = 32'h0;
  initial begin
    w_gnt = 1'b0; w_rv = 1'b0; w_rdata = 32'h0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        w_gnt = 1'b0; w_rv = 1'b0; w_has = 1'b0;
      end else begin
        w_rv    = w_has;
        w_rdata = w_last;
        w_gnt   = w_req;
        w_has   = w_gnt;
        w_last  = w_addr;
      end
    end
  end

  task automatic do_reset(input logic rdy, input logic g, input logic r);
    rst_ni = 1'b0;
    redirect_i = 1'b0;
    instr_ready_i = rdy; gnt_en = g; resp_en = r;
    repeat (2) step();
    gnt_cnt = 0;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [31:0] wpc [3];
    logic [31:0] wins[3];
    int n;
    instr_ready_i = 1'b1;
    #2 rst_ni = 1'b0;
    repeat (2) step();
    chk("rst_req",   instr_req_o,   0);
    chk("rst_addr",  instr_addr_o,  0);
    chk("rst_vld",   instr_valid_o, 0);
    chk("rst_instr", instr_o,       0);
    chk("rst_pc",    pc_o,          0);
    chk("rst_waddr", w_addr,        32'hFFFF_FFF8);

    // Boot stream, then a redirect colliding with rvalid and a handshake.
    rst_ni = 1'b1;
    chk("rel_req", instr_req_o, 0);
    step();
    chk("boot_req", instr_req_o, 1);
    chk("boot_addr", instr_addr_o, 0);
    chk("boot_vld0", instr_valid_o, 0);
    step();
    chk("boot_vld1", instr_valid_o, 0);
    chk("boot_addr1", instr_addr_o, 4);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("boot_vld", instr_valid_o, 1);
      chk("boot_pc", pc_o, 32'(4 * i));
      chk("boot_instr", instr_o, 32'(4 * i) ^ K);
    end
    step();
    chk("coll_pc", pc_o, 32'h18);
    redirect_i = 1'b1; redirect_addr_i = 32'h300;
    step();
    redirect_i = 1'b0;
    chk("coll_flush", instr_valid_o, 0);
    chk("coll_req", instr_req_o, 1);
    chk("coll_addr", instr_addr_o, 32'h300);
    step();
    chk("coll_vld2", instr_valid_o, 0);
    step();
    chk("coll_vld3", instr_valid_o, 1);
    chk("coll_pc3", pc_o, 32'h300);
    step();
    chk("coll_pc4", pc_o, 32'h304);

    // Backpressure: FIFO fills to DEPTH, head holds, then drains without gaps.
    do_reset(1'b0, 1'b1, 1'b1);
    repeat (10) step();
    chk("bp_grants", gnt_cnt, 3);
    chk("bp_req", instr_req_o, 0);
    chk("bp_vld", instr_valid_o, 1);
    chk("bp_pc", pc_o, 0);
    chk("bp_instr", instr_o, K);
    instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_vld", instr_valid_o, 1);
      chk("drain_pc", pc_o, 32'(4 * i));
      step();
    end

    // Redirect with two responses in flight.
    do_reset(1'b0, 1'b1, 1'b0);
    repeat (5) step();
    chk("rd_grants", gnt_cnt, 3);
    chk("rd_req", instr_req_o, 0);
    resp_en = 1'b1;
    step();
    resp_en = 1'b0;
    chk("rd_head", pc_o, 0);
    redirect_i = 1'b1; redirect_addr_i = 32'h100;
    step();
    redirect_i = 1'b0;
    chk("rd_flush", instr_valid_o, 0);
    chk("rd_addr", instr_addr_o, 32'h100);
    resp_en = 1'b1; instr_ready_i = 1'b1;
    step();
    chk("rd_drop1", instr_valid_o, 0);
    step();
    chk("rd_drop2", instr_valid_o, 0);
    step();
    chk("rd_vld", instr_valid_o, 1);
    chk("rd_pc", pc_o, 32'h100);
    chk("rd_instr", instr_o, 32'h100 ^ K);

    // Redirect while a request is held ungranted.
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (3) step();
    gnt_en = 1'b0;
    chk("pd_pc0", pc_o, 0);
    step();
    chk("pd_req", instr_req_o, 1);
    chk("pd_addr", instr_addr_o, 32'h8);
    chk("pd_pc4", pc_o, 32'h4);
    redirect_i = 1'b1; redirect_addr_i = 32'h203;
    step();
    redirect_i = 1'b0;
    chk("pd_hold_req", instr_req_o, 1);
    chk("pd_hold_addr", instr_addr_o, 32'h8);
    chk("pd_flush", instr_valid_o, 0);
    step();
    chk("pd_hold_addr2", instr_addr_o, 32'h8);
    gnt_en = 1'b1;
    step();
    chk("pd_new_addr", instr_addr_o, 32'h200);
    chk("pd_drop", instr_valid_o, 0);
    step();
    chk("pd_drop2", instr_valid_o, 0);
    step();
    chk("pd_vld", instr_valid_o, 1);
    chk("pd_pc", pc_o, 32'h200);

    // Asynchronous reset between edges with requests in flight.
    resp_en = 1'b0;
    repeat (2) step();
    #3 rst_ni = 1'b0;
    #1;
    chk("ar_req", instr_req_o, 0);
    chk("ar_vld", instr_valid_o, 0);
    chk("ar_pc", pc_o, 0);
    chk("ar_instr", instr_o, 0);
    chk("ar_addr", instr_addr_o, 0);
    step();
    rst_ni = 1'b1; resp_en = 1'b1; instr_ready_i = 1'b1;
    step();
    chk("ar_restart", instr_addr_o, 0);
    step();
    step();
    chk("ar_vld2", instr_valid_o, 1);
    chk("ar_pc2", pc_o, 0);

    // Wrap instance: first three PCs from 0xFFFF_FFF8.
    do_reset(1'b1, 1'b1, 1'b1);
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      step();
      if (w_valid) begin
        wpc[n] = w_pc; wins[n] = w_instr; n++;
      end
    end
    chk("wrap_n", n, 3);
    chk("wrap_pc0", wpc[0], 32'hFFFF_FFF8);
    chk("wrap_pc1", wpc[1], 32'hFFFF_FFFC);
    chk("wrap_pc2", wpc[2], 32'h0000_0000);
    chk("wrap_in2", wins[2], 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
